// File: rtl/mod_unit.sv
// mod_unit: byte-to-symbol modulator front end.
// Fetches one byte per rd strobe and emits it as two 4B/5B symbols,
// high nibble first, with mod_en marking data symbols on dmod.
// Outputs are registered from the next-state decode, so they follow the
// state register exactly and never see a combinational path from inputs.
module mod_unit #(
  parameter logic [4:0] IDLE_CODE = 5'b11111
) (
  input  logic       clk,
  input  logic       rst_n,    // synchronous, active-high despite the name
  input  logic       rdy,      // 1 = hold off fetching new bytes
  input  logic [7:0] data_in,
  output logic [4:0] dmod,
  output logic       rd,
  output logic       mod_en
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SYM_HI = 2'd2,
    ST_SYM_LO = 2'd3
  } state_t;

  // Standard 4B/5B data code table.
  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'h0:    code = 5'b11110;
      4'h1:    code = 5'b01001;
      4'h2:    code = 5'b10100;
      4'h3:    code = 5'b10101;
      4'h4:    code = 5'b01010;
      4'h5:    code = 5'b01011;
      4'h6:    code = 5'b01110;
      4'h7:    code = 5'b01111;
      4'h8:    code = 5'b10010;
      4'h9:    code = 5'b10011;
      4'hA:    code = 5'b10110;
      4'hB:    code = 5'b10111;
      4'hC:    code = 5'b11010;
      4'hD:    code = 5'b11011;
      4'hE:    code = 5'b11100;
      4'hF:    code = 5'b11101;
      default: code = 5'b11111;
    endcase
    return code;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] byte_r;
  logic [7:0] byte_nxt_s;
  logic [4:0] dmod_nxt_s;
  logic       rd_nxt_s;
  logic       mod_en_nxt_s;
  logic [4:0] dmod_r;
  logic       rd_r;
  logic       mod_en_r;

  // State and byte registers; reset discards any byte in flight.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= ST_IDLE;
      byte_r  <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      byte_r  <= byte_nxt_s;
    end
  end

  // Next-state logic; rdy only matters at byte boundaries (IDLE, SYM_LO).
  always_comb begin
    state_nxt_s = state_r;
    byte_nxt_s  = byte_r;
    case (state_r)
      ST_IDLE: begin
        if (!rdy) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_SYM_HI;
        byte_nxt_s  = data_in;
      end
      ST_SYM_HI: begin
        state_nxt_s = ST_SYM_LO;
      end
      ST_SYM_LO: begin
        if (!rdy) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the state/byte about to be registered.
  always_comb begin
    rd_nxt_s     = 1'b0;
    mod_en_nxt_s = 1'b0;
    dmod_nxt_s   = IDLE_CODE;
    case (state_nxt_s)
      ST_IDLE: begin
        rd_nxt_s = 1'b0;
      end
      ST_READ: begin
        rd_nxt_s = 1'b1;
      end
      ST_SYM_HI: begin
        mod_en_nxt_s = 1'b1;
        dmod_nxt_s   = enc_4b5b(byte_nxt_s[7:4]);
      end
      ST_SYM_LO: begin
        mod_en_nxt_s = 1'b1;
        dmod_nxt_s   = enc_4b5b(byte_nxt_s[3:0]);
      end
      default: begin
        dmod_nxt_s = IDLE_CODE;
      end
    endcase
  end

  // Output registers; they mirror the IDLE decode while in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_r     <= 1'b0;
      mod_en_r <= 1'b0;
      dmod_r   <= IDLE_CODE;
    end else begin
      rd_r     <= rd_nxt_s;
      mod_en_r <= mod_en_nxt_s;
      dmod_r   <= dmod_nxt_s;
    end
  end

  assign rd     = rd_r;
  assign mod_en = mod_en_r;
  assign dmod   = dmod_r;

endmodule

// File: tb/tb_mod_unit.sv
// tb_mod_unit: scoreboard bench for mod_unit. The stimulus process runs a
// byte-level reference model and queues the expected rd cycles and symbols;
// a monitor on the falling edge compares whatever the DUT presents.
module tb_mod_unit;

  localparam logic [4:0] IDLE = 5'b11111;
  localparam logic [4:0] ENC_TAB [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  typedef struct {
    int         c;
    logic [4:0] s;
  } sym_t;

  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic [7:0] data_in;
  logic [4:0] dmod;
  logic       rd;
  logic       mod_en;

  mod_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdy     (rdy),
    .data_in (data_in),
    .dmod    (dmod),
    .rd      (rd),
    .mod_en  (mod_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  bit         mon_on = 1'b0;
  sym_t       sym_q[$];
  int         rd_q[$];
  logic [7:0] bq[$];

  // Reference model state: a fetch is pending, symbols left, last byte taken.
  bit         m_rd   = 1'b0;
  int         m_left = 0;
  logic [7:0] m_last = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the reference model.
  task automatic step(input logic r, input logic y);
    logic [7:0] d;
    if (m_rd && bq.size() > 0) d = bq.pop_front();
    else d = 8'($urandom);
    rst_n   = r;
    rdy     = y;
    data_in = d;
    @(posedge clk);
    cyc++;
    if (r) begin
      sym_q.delete();
      rd_q.delete();
      m_rd   = 1'b0;
      m_left = 0;
      mon_on = 1'b1;
    end else if (m_rd) begin
      sym_q.push_back('{c: cyc,     s: ENC_TAB[d[7:4]]});
      sym_q.push_back('{c: cyc + 1, s: ENC_TAB[d[3:0]]});
      m_last = d;
      m_rd   = 1'b0;
      m_left = 2;
    end else if (m_left == 2) begin
      m_left = 1;
    end else begin
      m_left = 0;
      if (!y) begin
        m_rd = 1'b1;
        rd_q.push_back(cyc);
      end
    end
    #1;
  endtask

  // Monitor: compare presented symbols and rd strobes against the queues.
  always @(negedge clk) begin
    if (mon_on) begin
      bit exp_sym;
      bit exp_rd;
      while (sym_q.size() > 0 && sym_q[0].c < cyc) begin
        check("missing_symbol", 32'(mod_en), 32'd1);
        void'(sym_q.pop_front());
      end
      while (rd_q.size() > 0 && rd_q[0] < cyc) begin
        check("missing_rd", 32'(rd), 32'd1);
        void'(rd_q.pop_front());
      end
      exp_sym = (sym_q.size() > 0) && (sym_q[0].c == cyc);
      exp_rd  = (rd_q.size() > 0) && (rd_q[0] == cyc);
      check("mod_en", 32'(mod_en), 32'(exp_sym));
      if (exp_sym) begin
        sym_t e;
        e = sym_q.pop_front();
        if (mod_en) check("dmod_symbol", 32'(dmod), 32'(e.s));
      end else if (!mod_en) begin
        check("dmod_idle", 32'(dmod), 32'(IDLE));
      end
      check("rd", 32'(rd), 32'(exp_rd));
      if (exp_rd) void'(rd_q.pop_front());
    end
  end

  initial begin
    int guard;
    rst_n   = 1'b1;
    rdy     = 1'b1;
    data_in = 8'h00;
    for (int i = 1; i <= 16; i++) bq.push_back(8'(i));
    bq.push_back(8'hA5);
    bq.push_back(8'h3C);

    // Held reset with rdy=1: idle outputs.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Run until byte 3C is on its high symbol, then request a hold.
    guard = 0;
    do begin
      step(1'b0, 1'b0);
      guard++;
    end while (!(m_last == 8'h3C && m_left == 2) && guard < 200);
    check("reach_3C_sym_hi", 32'(guard < 200), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);

    // Table ends.
    bq.push_back(8'h00);
    bq.push_back(8'hFF);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    // Reset while a high symbol is on the line.
    guard = 0;
    do begin
      step(1'b0, 1'b0);
      guard++;
    end while (m_left != 2 && guard < 20);
    step(1'b1, 1'b0);
    check("byte_cleared", 32'(dut.byte_r), 32'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    // Randomized traffic with occasional holds and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0) ? 1'b1 : 1'b0, ($urandom_range(3) == 0) ? 1'b1 : 1'b0);
    end

    // Drain and confirm nothing expected is left outstanding.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("symbols_drained", 32'(sym_q.size()), 32'd0);
    check("rd_drained", 32'(rd_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
